// File: rtl/mmcm_ps_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmcm_ps_pkg
//  Description : Shared types and defaults for the MMCM dynamic phase-shift
//                controller (FSM states, error codes, period default).
//  Revision    : 1.0 - initial release
// ============================================================================
package mmcm_ps_pkg;

    // Fine phase steps in one CLKOUT0 period (56 x CLKOUT0_DIVIDE of 10).
    localparam int PERIOD_STEPS_DEF = 560;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } ps_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_TIMEOUT   = 2'd1,
        ERR_LOCK_LOST = 2'd2,
        ERR_ABORTED   = 2'd3
    } ps_err_t;

endpackage : mmcm_ps_pkg
`default_nettype wire

// File: rtl/mmcm_ps_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmcm_ps_ctrl
//  Description : Initiator for the MMCM dynamic phase-shift port. Turns a
//                signed step request into paced single-cycle psen pulses,
//                waits for psdone after each, and tracks the absolute fine
//                phase of CLKOUT0 modulo one output period.
//                Optional build macro PS_TIMEOUT_EN: abandon a step when
//                psdone has not arrived TIMEOUT_CYC cycles after psen.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmcm_ps_ctrl
    import mmcm_ps_pkg::*;
#(
    parameter int STEP_W       = 12,
    parameter int POS_W        = 10,
    parameter int PERIOD_STEPS = PERIOD_STEPS_DEF,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic              psclk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [STEP_W-1:0] req_steps,
    input  logic              abort,
    input  logic              pos_clear,
    input  logic              locked,
    output logic              psen,
    output logic              psincdec,
    input  logic              psdone,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [POS_W-1:0]  position,
    output logic              pos_valid,
    output logic [STEP_W-1:0] steps_left
);

    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(PERIOD_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    ps_state_t         state_q;
    ps_err_t           err_q;
    logic              psen_q;
    logic              psincdec_q;
    logic              done_q;
    logic [POS_W-1:0]  pos_q;
    logic              pos_valid_q;
    logic [STEP_W-1:0] steps_q;
    logic              abort_pend_q;

    logic [STEP_W-1:0] req_mag_d;
    logic [POS_W-1:0]  pos_next_d;
    logic              w_timeout;

    // Magnitude of the signed request; the most negative value maps to
    // 2^(STEP_W-1), which fits because the result is treated as unsigned.
    always_comb begin
        req_mag_d = req_steps;
        if (req_steps[STEP_W-1]) begin
            req_mag_d = (~req_steps) + STEP_ONE;
        end
    end

    // Position after one completed step in the latched direction, wrapping
    // at the period boundary in both directions.
    always_comb begin
        pos_next_d = pos_q;
        if (psincdec_q) begin
            pos_next_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else begin
            pos_next_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
        end
    end

`ifdef PS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_q;

    // Cycles elapsed since the outstanding psen; 1 in the first WAIT_DONE
    // cycle so that leaving on TO_LAST lands IDLE exactly TIMEOUT_CYC
    // cycles after psen.
    always_ff @(posedge psclk) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            to_cnt_q <= TO_W'(1);
        end else if (state_q == WAIT_DONE && to_cnt_q != TO_LAST) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign w_timeout = (to_cnt_q == TO_LAST);
`else
    // Never true: WAIT_DONE is left only by psdone, lock loss or reset.
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    // Main sequencer: request acceptance, psen pacing, position tracking
    // and error reporting, all outputs registered.
    always_ff @(posedge psclk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            err_q        <= ERR_NONE;
            psen_q       <= 1'b0;
            psincdec_q   <= 1'b0;
            done_q       <= 1'b0;
            pos_q        <= '0;
            pos_valid_q  <= 1'b1;
            steps_q      <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            psen_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    abort_pend_q <= 1'b0;
                    if (pos_clear) begin
                        pos_q       <= '0;
                        pos_valid_q <= 1'b1;
                    end
                    if (req_valid && locked) begin
                        err_q      <= ERR_NONE;
                        psincdec_q <= ~req_steps[STEP_W-1];
                        steps_q    <= req_mag_d;
                        if (req_mag_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            psen_q  <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (!locked) begin
                        state_q     <= IDLE;
                        err_q       <= ERR_LOCK_LOST;
                        pos_valid_q <= 1'b0;
                        steps_q     <= '0;
                    end else begin
                        // The psen of this cycle is already on its way, so an
                        // abort here only takes effect after its psdone.
                        state_q <= WAIT_DONE;
                        if (abort) begin
                            abort_pend_q <= 1'b1;
                        end
                    end
                end

                WAIT_DONE: begin
                    if (!locked) begin
                        state_q     <= IDLE;
                        err_q       <= ERR_LOCK_LOST;
                        pos_valid_q <= 1'b0;
                        steps_q     <= '0;
                    end else if (psdone) begin
                        pos_q   <= pos_next_d;
                        steps_q <= steps_q - STEP_ONE;
                        if (abort_pend_q || abort) begin
                            state_q <= IDLE;
                            err_q   <= ERR_ABORTED;
                        end else if (steps_q == STEP_ONE) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            psen_q  <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        state_q     <= IDLE;
                        err_q       <= ERR_TIMEOUT;
                        pos_valid_q <= 1'b0;
                        steps_q     <= '0;
                    end else if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE) && locked;
    assign busy       = (state_q != IDLE);
    assign psen       = psen_q;
    assign psincdec   = psincdec_q;
    assign done       = done_q;
    assign err_code   = err_q;
    assign position   = pos_q;
    assign pos_valid  = pos_valid_q;
    assign steps_left = steps_q;

endmodule : mmcm_ps_ctrl
`default_nettype wire

// File: tb/tb_mmcm_ps_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmcm_ps_ctrl
//  Description : Self-checking bench for mmcm_ps_ctrl. Expected outcomes are
//                queued per request; a monitor pops and compares on every
//                completion (done pulse or busy falling). Includes a psdone
//                BFM with fixed latency and a withhold switch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmcm_ps_ctrl;

    localparam int STEP_W      = 12;
    localparam int POS_W       = 10;
    localparam int PERIOD      = 560;
    localparam int TIMEOUT_CYC = 64;
    localparam int BFM_LAT     = 12;
    localparam int WAIT_LIMIT  = 40000;

    typedef struct {
        bit exp_done;
        int err;
        int pos;
        bit pos_valid;
        int npsen;
        bit dir;
        bit busy;
        int lat;       // -1: not checked
        bit lat_acc;   // latency measured from acceptance instead of last psen
    } exp_t;

    logic              psclk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [STEP_W-1:0] req_steps;
    logic              abort;
    logic              pos_clear;
    logic              locked;
    logic              psen;
    logic              psincdec;
    logic              psdone;
    logic              busy;
    logic              done;
    logic [1:0]        err_code;
    logic [POS_W-1:0]  position;
    logic              pos_valid;
    logic [STEP_W-1:0] steps_left;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   withhold = 1'b0;
    int   mdl_pos = 0;
    bit   mdl_valid = 1'b1;

    mmcm_ps_ctrl #(
        .STEP_W      (STEP_W),
        .POS_W       (POS_W),
        .PERIOD_STEPS(PERIOD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .psclk     (psclk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_steps (req_steps),
        .abort     (abort),
        .pos_clear (pos_clear),
        .locked    (locked),
        .psen      (psen),
        .psincdec  (psincdec),
        .psdone    (psdone),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .position  (position),
        .pos_valid (pos_valid),
        .steps_left(steps_left)
    );

    initial forever #5 psclk = ~psclk;

    always @(posedge psclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pmod(input int v);
        int r;
        r = v % PERIOD;
        if (r < 0) r += PERIOD;
        return r;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // psdone BFM: one-cycle psdone BFM_LAT cycles after each psen.
    initial begin
        int cd;
        cd = 0;
        psdone = 1'b0;
        forever begin
            @(posedge psclk);
            #1;
            psdone = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && !withhold) psdone = 1'b1;
            end
            if (psen) cd = BFM_LAT;
        end
    end

    // Monitor: psen pacing/direction and per-request completion scoreboard.
    initial begin
        exp_t e;
        int   npsen_cnt;
        int   last_psen;
        bit   busy_seen;
        bit   busy_prev;
        npsen_cnt = 0;
        last_psen = -1;
        busy_seen = 1'b0;
        busy_prev = 1'b0;
        forever begin
            @(negedge psclk);
            if (resetn) begin
                if (psen) begin
                    npsen_cnt++;
                    if (exp_q.size() != 0) chk("psincdec_at_psen", int'(psincdec), int'(exp_q[0].dir));
                    if (npsen_cnt == 1) chk("first_psen_after_accept", cyc - acc_cyc, 1);
                    else chk("psen_spacing_ok", int'((cyc - last_psen) >= BFM_LAT + 1), 1);
                    last_psen = cyc;
                end
                if (busy) busy_seen = 1'b1;
                if (done || (busy_prev && !busy)) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_completion: got done=%0d err=%0d expected no event", done, err_code);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_pulse", int'(done), int'(e.exp_done));
                        chk("err_code", int'(err_code), e.err);
                        chk("position", int'(position), e.pos);
                        chk("pos_valid", int'(pos_valid), int'(e.pos_valid));
                        chk("psen_count", npsen_cnt, e.npsen);
                        chk("busy_seen", int'(busy_seen), int'(e.busy));
                        if (e.lat >= 0) begin
                            if (e.lat_acc) chk("latency_from_accept", cyc - acc_cyc, e.lat);
                            else chk("latency_from_psen", cyc - last_psen, e.lat);
                        end
                    end
                    npsen_cnt = 0;
                    last_psen = -1;
                    busy_seen = 1'b0;
                end
            end
            busy_prev = busy;
        end
    end

    // Global guard so the run always ends.
    initial begin
        #(80000 * 10);
        n_errors++;
        $display("FAIL watchdog: got no end of stimulus expected finish within 80000 cycles");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge psclk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < WAIT_LIMIT) begin
            step(1);
            n++;
        end
        if (n >= WAIT_LIMIT) begin
            n_checks++;
            n_errors++;
            $display("FAIL completion_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        step(2);
    endtask

    task automatic wait_psen(input int n);
        int seen;
        int t;
        seen = 0;
        t = 0;
        while (seen < n && t < 2000) begin
            if (psen) seen++;
            if (seen < n) begin
                step(1);
                t++;
            end
        end
        if (seen < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL psen_wait: got %0d psen expected %0d", seen, n);
        end
    endtask

    // Drive one request for a single cycle (caller has queued expectations).
    task automatic send(input int steps);
        int t;
        t = 0;
        while (!req_ready && t < 100) begin
            step(1);
            t++;
        end
        req_valid = 1'b1;
        req_steps = STEP_W'(steps);
        acc_cyc   = cyc;
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        pos_clear = 1'b1;
        step(1);
        pos_clear = 1'b0;
        mdl_pos   = 0;
        mdl_valid = 1'b1;
        step(1);
    endtask

    // Normal request: expected outcome from the phase-arithmetic model.
    task automatic issue(input int steps, input bit blip);
        exp_t e;
        int   mag;
        mag         = iabs(steps);
        e.exp_done  = 1'b1;
        e.err       = 0;
        e.pos       = pmod(mdl_pos + steps);
        e.pos_valid = mdl_valid;
        e.npsen     = mag;
        e.dir       = (steps >= 0);
        e.busy      = (mag != 0);
        e.lat       = (mag == 0) ? 1 : BFM_LAT + 1;
        e.lat_acc   = (mag == 0);
        exp_q.push_back(e);
        send(steps);
        if (mag != 0) chk("steps_left_init", int'(steps_left), mag);
        if (blip && mag != 0) begin
            step(2);
            req_valid = 1'b1;
            req_steps = STEP_W'($urandom_range(1, 50));
            pos_clear = 1'b1;
            step(1);
            req_valid = 1'b0;
            pos_clear = 1'b0;
        end
        wait_idle();
        mdl_pos = e.pos;
    endtask

    initial begin
        exp_t e;
        int   p;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_steps = '0;
        abort     = 1'b0;
        pos_clear = 1'b0;
        locked    = 1'b1;
        step(4);
        resetn = 1'b1;

        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_psen", int'(psen), 0);
        chk("rst_psincdec", int'(psincdec), 0);
        chk("rst_err", int'(err_code), 0);
        chk("rst_position", int'(position), 0);
        chk("rst_pos_valid", int'(pos_valid), 1);
        chk("rst_steps_left", int'(steps_left), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        step(2);

        // +3 from 0 with a busy-time blip that must be ignored
        issue(3, 1'b1);
        // to position 1, then -3 across the wrap
        pulse_clear();
        issue(1, 1'b0);
        issue(-3, 1'b0);
        chk("pos_after_wrap", int'(position), 558);
        // zero-magnitude request
        issue(0, 1'b0);

        // abort during WAIT_DONE of step 2 of 5
        pulse_clear();
        e.exp_done = 1'b0; e.err = 3; e.pos = 2; e.pos_valid = 1'b1;
        e.npsen = 2; e.dir = 1'b1; e.busy = 1'b1; e.lat = BFM_LAT + 1; e.lat_acc = 1'b0;
        exp_q.push_back(e);
        send(5);
        wait_psen(2);
        step(3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        wait_idle();
        mdl_pos = 2;
        abort = 1'b1;
        step(2);
        abort = 1'b0;
        chk("abort_idle_no_effect", int'(busy), 0);

        // lock loss in WAIT_DONE of step 1
        p = mdl_pos;
        e.exp_done = 1'b0; e.err = 2; e.pos = p; e.pos_valid = 1'b0;
        e.npsen = 1; e.dir = 1'b1; e.busy = 1'b1; e.lat = -1; e.lat_acc = 1'b0;
        exp_q.push_back(e);
        send(4);
        wait_psen(1);
        step(3);
        locked = 1'b0;
        wait_idle();
        chk("ready_while_unlocked", int'(req_ready), 0);
        req_valid = 1'b1;
        req_steps = STEP_W'(7);
        step(2);
        req_valid = 1'b0;
        step(15);
        chk("late_psdone_ignored", int'(position), p);
        chk("err_holds", int'(err_code), 2);
        locked = 1'b1;
        step(1);
        chk("ready_relocked", int'(req_ready), 1);
        pulse_clear();
        chk("clear_position", int'(position), 0);
        chk("clear_pos_valid", int'(pos_valid), 1);

        // psdone withheld
        withhold = 1'b1;
`ifdef PS_TIMEOUT_EN
        e.exp_done = 1'b0; e.err = 1; e.pos = 0; e.pos_valid = 1'b0;
        e.npsen = 1; e.dir = 1'b1; e.busy = 1'b1; e.lat = TIMEOUT_CYC; e.lat_acc = 1'b0;
        exp_q.push_back(e);
        send(2);
        wait_idle();
`else
        e.exp_done = 1'b0; e.err = 2; e.pos = 0; e.pos_valid = 1'b0;
        e.npsen = 1; e.dir = 1'b1; e.busy = 1'b1; e.lat = -1; e.lat_acc = 1'b0;
        exp_q.push_back(e);
        send(2);
        step(200);
        chk("no_timeout_busy", int'(busy), 1);
        chk("no_timeout_err", int'(err_code), 0);
        locked = 1'b0;
        wait_idle();
        locked = 1'b1;
`endif
        withhold = 1'b0;
        step(20);
        pulse_clear();

        // randomized requests
        for (int i = 0; i < 16; i++) begin
            issue(int'($urandom_range(0, 64)) - 32, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                pulse_clear();
                chk("rand_clear_position", int'(position), 0);
            end
        end

        // most negative request
        issue(-(1 << (STEP_W - 1)), 1'b0);

        step(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mmcm_ps_ctrl
`default_nettype wire
